gate_sweep_checker: RTL and testbench
=====================================

# gate_sweep_checker

Self-checking stimulus/monitor for the single-output logic-gate primitives (inverter, two-input gates and similar).
- Drives every input combination into a gate-under-test, waits a programmable settle time, samples the gate's output, and compares it against a caller-supplied truth table.
- Reports pass/fail, a failure count, the first failing vector, and the full observed truth table.
- Sits beside each gate primitive in the simulation and bring-up tree as its drive/observe counterpart.

## Interface

Parameters:
- `N_IN`, default 1: gate input count, legal range 1..4. Vector count V = 2^N_IN.
- `SETTLE`, default 1: cycles each vector is held before its sample cycle, legal range 1..15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a sweep; sampled only in IDLE.
- `expected` input V: expected truth table; bit i is the expected gate output for input vector i. Latched when `start` is accepted.
- `dut_in` output N_IN: drive to the gate inputs; bit 0 goes to the gate's first input (A).
- `dut_out` input 1: gate output (Z).
- `busy` output 1: high while a sweep is in progress.
- `done` output 1: single-cycle pulse when results are valid.
- `pass` output 1: high when the last sweep had zero mismatches.
- `fail_count` output N_IN+1: number of mismatching vectors in the last sweep, range 0..V.
- `first_fail` output N_IN: index of the lowest mismatching vector; 0 when `fail_count` is 0.
- `observed` output V: sampled `dut_out` per vector; bit i corresponds to vector i.

## Operation

States: IDLE, SETTLE, SAMPLE, DONE.

- **IDLE**
  - `start`=1: latch `expected`; clear `fail_count`, `first_fail` and `observed`; set idx=0; set `dut_in`=0; load the settle counter with SETTLE-1; go to SETTLE.
  - Otherwise stay in IDLE.
- **SETTLE**
  - Decrement the counter.
  - When the counter reaches 0, go to SAMPLE. The vector is therefore held for exactly SETTLE cycles in this state.
- **SAMPLE**
  - Write `observed[idx]` = `dut_out`.
  - If `dut_out` != `expected[idx]`: increment `fail_count`; if this is the first mismatch, set `first_fail` = idx.
  - If idx = V-1, go to DONE.
  - Otherwise: idx+1, `dut_in` = idx+1, reload the counter, go to SETTLE.
- **DONE**
  - Assert `done` for one cycle.
  - `pass` = (`fail_count` == 0).
  - Set `dut_in` = 0.
  - Go to IDLE.

Rules:
- `busy` = 1 in SETTLE and SAMPLE; 0 in IDLE and DONE.
- `start` is ignored in SETTLE, SAMPLE and DONE; there is no queuing.
- Changes to `expected` after `start` is accepted have no effect on the current sweep.
- `pass`, `fail_count`, `first_fail` and `observed` hold their values from DONE until the next accepted `start`.
- `pass` is also cleared on an accepted `start`.
- `fail_count` width N_IN+1 holds V exactly; no saturation logic is needed.
- Reset values: state IDLE; `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail`=0, `observed`=0.
- `rst` in any state, including mid-sweep, forces all reset values on the next edge. Partial results are discarded.
- `rst` and `start` high together: reset wins; `start` is not accepted.

## Timing

- Start accepted at edge E0. Vector i is driven from edge E0 + i·(SETTLE+1).
- `dut_out` for vector i is sampled at edge E0 + (i+1)·(SETTLE+1).
- `dut_in` is stable for SETTLE+1 cycles before each sample.
- `done` is high in the cycle after edge E0 + V·(SETTLE+1).
  - N_IN=1, SETTLE=1: 4 cycles.
  - N_IN=2, SETTLE=3: 16 cycles.
- Earliest next accepted `start` is 2 cycles after the `done` rises (one DONE cycle, then `start` sampled in IDLE).
- Every output is registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package `dds_pkg` holds:
  - state encoding constants: IDLE=0, SETTLE=1, SAMPLE=2, DONE=3;
  - `SETTLE_W` = 4;
  - a vector-count helper V(N_IN) = 1<<N_IN.
- One sub-module: `settle_timer`, a loadable down-counter with `load`, `value`, `zero` outputs, used by SETTLE.
- Everything else stays in the top-level FSM.

## Test plan

1. N_IN=1, SETTLE=1, gate = inverter, `expected`=2'b01, pulse `start`:
   - `done` 4 cycles after the start edge;
   - `pass`=1, `fail_count`=0, `observed`=2'b01.
2. N_IN=1, gate = buffer (Z=A), `expected`=2'b01:
   - `pass`=0, `fail_count`=2, `first_fail`=0, `observed`=2'b10.
3. N_IN=2, SETTLE=3, gate = AND, `expected`=4'b1000:
   - `pass`=1, `done` at 16 cycles;
   - `dut_in` steps 0,1,2,3, each held 4 cycles.
4. N_IN=2, gate = OR, `expected`=4'b1000 (AND table):
   - `fail_count`=2, `first_fail`=1, `observed`=4'b1110.
5. Pulse `start` again while `busy`:
   - no restart, no change in timing;
   - `done` fires exactly once.
6. Assert `rst` during the vector-1 SETTLE:
   - next cycle all outputs at reset values, state IDLE;
   - a fresh `start` then completes a normal sweep.

Source files
------------

// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checker: state encoding, settle
// counter width and the vector-count helper.
package dds_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int SETTLE_W = 4;

    // Number of input vectors for a gate with n inputs.
    function automatic int vcount(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Bundle between the sweep checker and its environment: sweep control,
// gate drive/observe and the result outputs.
interface gate_sweep_checker_if
    import dds_pkg::*;
#(
    parameter int N_IN = 1
);
    localparam int V = vcount(N_IN);

    logic            start;
    logic [V-1:0]    expected;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   fail_count;
    logic [N_IN-1:0] first_fail;
    logic [V-1:0]    observed;

    // Environment side: requests sweeps, supplies the table, models the gate.
    modport master (
        output start, expected, dut_out,
        input  dut_in, busy, done, pass, fail_count, first_fail, observed
    );

    // Checker side.
    modport slave (
        input  start, expected, dut_out,
        output dut_in, busy, done, pass, fail_count, first_fail, observed
    );

endinterface

// File: rtl/gate_sweep_checker_settle_timer.sv
// Loadable down-counter that times how long each vector is held.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] r_value;

    // Load takes priority over counting; caller only enables while nonzero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= load_val;
        end else if (en) begin
            r_value <= r_value - W'(1);
        end
    end

    assign value = r_value;
    assign zero  = (r_value == '0);

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives every input vector into a gate, samples its output after a settle
// period and compares the result against an expected truth table.
module gate_sweep_checker
    import dds_pkg::*;
#(
    parameter int N_IN   = 1,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_sweep_checker_if.slave  bus
);

    localparam int V   = vcount(N_IN);
    localparam int FCW = N_IN + 1;

    state_t          r_state;
    logic [V-1:0]    r_exp;
    logic [V-1:0]    r_obs;
    logic [N_IN-1:0] r_idx;
    logic [N_IN-1:0] r_din;
    logic [N_IN-1:0] r_ff;
    logic [FCW-1:0]  r_fc;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;

    logic                w_load;
    logic                w_zero;
    logic [SETTLE_W-1:0] w_value;
    logic                w_mismatch;
    logic                w_last;
    logic [FCW-1:0]      w_fc_next;

    assign w_mismatch = (bus.dut_out != r_exp[r_idx]);
    assign w_last     = (r_idx == N_IN'(V - 1));
    assign w_fc_next  = r_fc + FCW'(w_mismatch);
    assign w_load     = ((r_state == S_IDLE) && bus.start) ||
                        ((r_state == S_SAMPLE) && !w_last);

    settle_timer #(
        .W(SETTLE_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (SETTLE_W'(SETTLE - 1)),
        .en       ((r_state == S_SETTLE) && (w_value != '0)),
        .value    (w_value),
        .zero     (w_zero)
    );

    // Sweep FSM; pass/done are set on the final sample edge so they are
    // already valid during the single DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_exp   <= '0;
            r_obs   <= '0;
            r_idx   <= '0;
            r_din   <= '0;
            r_ff    <= '0;
            r_fc    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_exp   <= bus.expected;
                        r_obs   <= '0;
                        r_fc    <= '0;
                        r_ff    <= '0;
                        r_pass  <= 1'b0;
                        r_idx   <= '0;
                        r_din   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (w_zero) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_obs[r_idx] <= bus.dut_out;
                    if (w_mismatch) begin
                        r_fc <= w_fc_next;
                        if (r_fc == '0) begin
                            r_ff <= r_idx;
                        end
                    end
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_fc_next == '0);
                        r_din   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx   <= r_idx + N_IN'(1);
                        r_din   <= r_idx + N_IN'(1);
                        r_state <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_in     = r_din;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.fail_count = r_fc;
    assign bus.first_fail = r_ff;
    assign bus.observed   = r_obs;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (1-input/settle 1 and
// 2-input/settle 3) sweep lookup-table gates; results are compared against
// a truth-table model computed in the bench.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gate_sweep_checker_if #(.N_IN(1)) if0 ();
    gate_sweep_checker_if #(.N_IN(2)) if1 ();

    gate_sweep_checker #(.N_IN(1), .SETTLE(1)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    gate_sweep_checker #(.N_IN(2), .SETTLE(3)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    logic       r_start [2];
    logic [3:0] r_exp   [2];
    logic [3:0] gtab    [2];

    logic [3:0] w_obs  [2];
    logic [2:0] w_fc   [2];
    logic [1:0] w_ff   [2];
    logic [1:0] w_din  [2];
    logic       w_busy [2];
    logic       w_done [2];
    logic       w_pass [2];

    // Gate under test is a lookup table indexed by the driven vector.
    assign if0.start    = r_start[0];
    assign if0.expected = r_exp[0][1:0];
    assign if0.dut_out  = gtab[0][if0.dut_in];
    assign if1.start    = r_start[1];
    assign if1.expected = r_exp[1];
    assign if1.dut_out  = gtab[1][if1.dut_in];

    assign w_obs[0]  = {2'b00, if0.observed};
    assign w_fc[0]   = {1'b0, if0.fail_count};
    assign w_ff[0]   = {1'b0, if0.first_fail};
    assign w_din[0]  = {1'b0, if0.dut_in};
    assign w_busy[0] = if0.busy;
    assign w_done[0] = if0.done;
    assign w_pass[0] = if0.pass;
    assign w_obs[1]  = if1.observed;
    assign w_fc[1]   = if1.fail_count;
    assign w_ff[1]   = if1.first_fail;
    assign w_din[1]  = if1.dut_in;
    assign w_busy[1] = if1.busy;
    assign w_done[1] = if1.done;
    assign w_pass[1] = if1.pass;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset(input int k);
        check("rst_busy", 32'(w_busy[k]), 32'd0);
        check("rst_done", 32'(w_done[k]), 32'd0);
        check("rst_pass", 32'(w_pass[k]), 32'd0);
        check("rst_fc",   32'(w_fc[k]),   32'd0);
        check("rst_ff",   32'(w_ff[k]),   32'd0);
        check("rst_obs",  32'(w_obs[k]),  32'd0);
        check("rst_din",  32'(w_din[k]),  32'd0);
    endtask

    // One sweep on instance k with gate table g and expected table e.
    // restart_at / rst_at: cycle after the start edge at which to pulse
    // start or rst (-1 = never).
    task automatic run_sweep(input int k, input logic [3:0] g, input logic [3:0] e,
                             input int restart_at, input int rst_at);
        int         nv;
        int         per;
        int         tot;
        int         j;
        int         fc;
        int         ff;
        bit         seen;
        logic [3:0] mask;
        logic [3:0] obs_ref;
        logic [3:0] mis;

        nv   = (k == 0) ? 2 : 4;
        per  = (k == 0) ? 2 : 4;
        tot  = nv * per;
        mask = 4'((1 << nv) - 1);
        obs_ref = g & mask;
        mis  = (g ^ e) & mask;
        fc   = $countones(mis);
        ff   = 0;
        for (int i = nv - 1; i >= 0; i--) begin
            if (mis[i]) ff = i;
        end

        gtab[k] = g;
        @(negedge clk);
        r_exp[k]   = e;
        r_start[k] = 1'b1;
        @(negedge clk);
        r_start[k] = 1'b0;
        r_exp[k]   = 4'($urandom);

        j    = 0;
        seen = 1'b0;
        while (j <= tot + 8) begin
            if (j == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                r_start[k] = 1'b0;
                check_reset(k);
                return;
            end
            r_start[k] = (j == restart_at);
            if (j == 0) begin
                check("start_clr_pass", 32'(w_pass[k]), 32'd0);
                check("start_clr_fc",   32'(w_fc[k]),   32'd0);
                check("start_clr_obs",  32'(w_obs[k]),  32'd0);
            end
            if (w_done[k]) begin
                seen = 1'b1;
                break;
            end
            check("din_step", 32'(w_din[k]), 32'(j / per));
            check("busy_high", 32'(w_busy[k]), 32'd1);
            @(negedge clk);
            j++;
        end
        r_start[k] = 1'b0;

        check("done_latency", seen ? 32'(j) : 32'hFFFF_FFFF, 32'(tot));
        if (!seen) return;

        check("pass",       32'(w_pass[k]), 32'(fc == 0));
        check("fail_count", 32'(w_fc[k]),   32'(fc));
        check("first_fail", 32'(w_ff[k]),   32'(ff));
        check("observed",   32'(w_obs[k]),  32'(obs_ref));
        check("busy_done",  32'(w_busy[k]), 32'd0);

        @(negedge clk);
        check("done_pulse", 32'(w_done[k]), 32'd0);
        check("no_queue",   32'(w_busy[k]), 32'd0);
        check("obs_hold",   32'(w_obs[k]),  32'(obs_ref));
        check("fc_hold",    32'(w_fc[k]),   32'(fc));
        check("din_idle",   32'(w_din[k]),  32'd0);
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] e;
        int         k;

        r_start[0] = 1'b0;
        r_start[1] = 1'b0;
        r_exp[0]   = '0;
        r_exp[1]   = '0;
        gtab[0]    = '0;
        gtab[1]    = '0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset(0);
        check_reset(1);

        // Inverter, then buffer, on the 1-input instance.
        run_sweep(0, 4'b0001, 4'b0001, -1, -1);
        run_sweep(0, 4'b0010, 4'b0001, -1, -1);
        // AND, then OR against the AND table, on the 2-input instance.
        run_sweep(1, 4'b1000, 4'b1000, -1, -1);
        run_sweep(1, 4'b1110, 4'b1000, -1, -1);
        // Start pulsed mid-sweep is ignored.
        run_sweep(1, 4'b1000, 4'b1000, 5, -1);
        // Reset during vector-1 settle, then a clean sweep.
        run_sweep(1, 4'b1000, 4'b1000, -1, 4);
        run_sweep(1, 4'b0110, 4'b0110, -1, -1);
        run_sweep(0, 4'b0001, 4'b0001, -1, 2);
        run_sweep(0, 4'b0001, 4'b0011, -1, -1);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst        = 1'b1;
        r_start[0] = 1'b1;
        r_exp[0]   = 4'b0001;
        @(negedge clk);
        rst        = 1'b0;
        r_start[0] = 1'b0;
        check("rst_start_busy", 32'(w_busy[0]), 32'd0);
        @(negedge clk);
        check("rst_start_idle", 32'(w_busy[0]), 32'd0);

        // Random gates and tables.
        for (int n = 0; n < 24; n++) begin
            k = int'($urandom_range(0, 1));
            g = 4'($urandom);
            e = ($urandom_range(0, 2) == 0) ? g : 4'($urandom);
            run_sweep(k, g, e, ($urandom_range(0, 3) == 0) ? 3 : -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
